// File: rtl/ni_rd_hist_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ni_rd_hist_ctrl_if
// Description : Bundle of control, pixel, RAM and readout signals of the
//               NI/RD histogram sequencer. The master modport is the
//               controller's view; the slave modport is the surrounding
//               system (pixel source, both RAMs, feature-vector packer).
// Revision    : 1.0 - initial release
// ============================================================================
interface ni_rd_hist_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 24
);
    logic             i_start;
    logic             i_frame_end;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_ni_code;
    logic [WIDTH-1:0] i_rd_code;

    logic [WIDTH-1:0] o_ni_raddr;
    logic [WIDTH-1:0] o_rd_raddr;
    logic [CNT_W-1:0] i_ni_rdata;
    logic [CNT_W-1:0] i_rd_rdata;
    logic [WIDTH-1:0] o_ni_waddr;
    logic [WIDTH-1:0] o_rd_waddr;
    logic [CNT_W-1:0] o_ni_wdata;
    logic [CNT_W-1:0] o_rd_wdata;
    logic             o_ni_wren;
    logic             o_rd_wren;

    logic             o_bin_valid;
    logic             i_bin_ready;
    logic [WIDTH-1:0] o_bin_idx;
    logic [CNT_W-1:0] o_ni_count;
    logic [CNT_W-1:0] o_rd_count;
    logic             o_busy;
    logic             o_done;

    modport master (
        input  i_start, i_frame_end, i_valid, i_ni_code, i_rd_code,
               i_ni_rdata, i_rd_rdata, i_bin_ready,
        output o_ready, o_ni_raddr, o_rd_raddr, o_ni_waddr, o_rd_waddr,
               o_ni_wdata, o_rd_wdata, o_ni_wren, o_rd_wren,
               o_bin_valid, o_bin_idx, o_ni_count, o_rd_count, o_busy, o_done
    );

    modport slave (
        output i_start, i_frame_end, i_valid, i_ni_code, i_rd_code,
               i_ni_rdata, i_rd_rdata, i_bin_ready,
        input  o_ready, o_ni_raddr, o_rd_raddr, o_ni_waddr, o_rd_waddr,
               o_ni_wdata, o_rd_wdata, o_ni_wren, o_rd_wren,
               o_bin_valid, o_bin_idx, o_ni_count, o_rd_count, o_busy, o_done
    );
endinterface
`default_nettype wire

// File: rtl/ni_rd_hist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ni_rd_hist_ctrl
// Description : Sequencer for the paired NI/RD histogram RAMs. Clears both
//               RAMs at frame start, accumulates one NI and one RD code per
//               accepted pixel through a read-modify-write pipeline with
//               same-address forwarding, then streams all bins out under a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module ni_rd_hist_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int CNT_W = 24
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst,
    ni_rd_hist_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ACCUM  = 3'd2,
        S_DRAIN  = 3'd3,
        S_RD_REQ = 3'd4,
        S_RD_OUT = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [WIDTH-1:0] c_last_bin = WIDTH'(DEPTH - 1);

    state_t           state_q,      state_d;
    logic [WIDTH-1:0] cnt_q,        cnt_d;        // clear address, then readout bin
    logic             s1_valid_q,   s1_valid_d;
    logic [WIDTH-1:0] s1_ni_addr_q, s1_ni_addr_d;
    logic [WIDTH-1:0] s1_rd_addr_q, s1_rd_addr_d;
    logic             ni_fwd_q,     ni_fwd_d;
    logic             rd_fwd_q,     rd_fwd_d;
    logic [CNT_W-1:0] ni_prev_q,    ni_prev_d;    // last value written to NI RAM
    logic [CNT_W-1:0] rd_prev_q,    rd_prev_d;    // last value written to RD RAM
    logic             bin_valid_q,  bin_valid_d;
    logic [WIDTH-1:0] bin_idx_q,    bin_idx_d;

    logic             accept;
    logic [CNT_W-1:0] ni_base,  rd_base;
    logic [CNT_W-1:0] ni_inc,   rd_inc;
    logic [WIDTH-1:0] ni_raddr, rd_raddr;
    logic [WIDTH-1:0] ni_waddr, rd_waddr;
    logic [CNT_W-1:0] ni_wdata, rd_wdata;
    logic             ni_wren,  rd_wren;

    assign accept = (state_q == S_ACCUM) && bus.i_valid;

    // Stage-1 increment and RAM port muxing; writes are gated so nothing
    // leaks onto the write bus unless a clear or stage-1 update is live.
    always_comb begin
        // A back-to-back hit on the same bin reads stale RAM data (old data on
        // a same-edge read/write), so the value just written is used instead.
        ni_base  = ni_fwd_q ? ni_prev_q : bus.i_ni_rdata;
        rd_base  = rd_fwd_q ? rd_prev_q : bus.i_rd_rdata;
        ni_inc   = (&ni_base) ? ni_base : ni_base + CNT_W'(1);
        rd_inc   = (&rd_base) ? rd_base : rd_base + CNT_W'(1);

        ni_waddr = '0;
        rd_waddr = '0;
        ni_wdata = '0;
        rd_wdata = '0;
        ni_wren  = 1'b0;
        rd_wren  = 1'b0;
        if (state_q == S_CLEAR) begin
            ni_waddr = cnt_q;
            rd_waddr = cnt_q;
            ni_wren  = 1'b1;
            rd_wren  = 1'b1;
        end else if (s1_valid_q) begin
            ni_waddr = s1_ni_addr_q;
            rd_waddr = s1_rd_addr_q;
            ni_wdata = ni_inc;
            rd_wdata = rd_inc;
            ni_wren  = 1'b1;
            rd_wren  = 1'b1;
        end

        case (state_q)
            S_ACCUM: begin
                ni_raddr = bus.i_ni_code;
                rd_raddr = bus.i_rd_code;
            end
            // Address is held through RD_OUT so the registered read data stays
            // stable until the consumer takes the bin.
            S_RD_REQ, S_RD_OUT: begin
                ni_raddr = cnt_q;
                rd_raddr = cnt_q;
            end
            default: begin
                ni_raddr = '0;
                rd_raddr = '0;
            end
        endcase
    end

    // Next-state logic for the FSM, the pixel pipeline and the readout registers.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        s1_valid_d   = accept;
        s1_ni_addr_d = accept ? bus.i_ni_code : s1_ni_addr_q;
        s1_rd_addr_d = accept ? bus.i_rd_code : s1_rd_addr_q;
        ni_fwd_d     = accept && s1_valid_q && (s1_ni_addr_q == bus.i_ni_code);
        rd_fwd_d     = accept && s1_valid_q && (s1_rd_addr_q == bus.i_rd_code);
        ni_prev_d    = ni_wdata;
        rd_prev_d    = rd_wdata;
        bin_valid_d  = bin_valid_q;
        bin_idx_d    = bin_idx_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                cnt_d = cnt_q + WIDTH'(1);
                if (cnt_q == c_last_bin) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.i_frame_end) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_RD_REQ;
                cnt_d   = '0;
            end
            S_RD_REQ: begin
                state_d     = S_RD_OUT;
                bin_valid_d = 1'b1;
                bin_idx_d   = cnt_q;
            end
            S_RD_OUT: begin
                if (bus.i_bin_ready) begin
                    bin_valid_d = 1'b0;
                    cnt_d       = cnt_q + WIDTH'(1);
                    state_d     = (cnt_q == c_last_bin) ? S_DONE : S_RD_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; asynchronous reset returns everything to IDLE and zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_ni_addr_q <= '0;
            s1_rd_addr_q <= '0;
            ni_fwd_q     <= 1'b0;
            rd_fwd_q     <= 1'b0;
            ni_prev_q    <= '0;
            rd_prev_q    <= '0;
            bin_valid_q  <= 1'b0;
            bin_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            s1_valid_q   <= s1_valid_d;
            s1_ni_addr_q <= s1_ni_addr_d;
            s1_rd_addr_q <= s1_rd_addr_d;
            ni_fwd_q     <= ni_fwd_d;
            rd_fwd_q     <= rd_fwd_d;
            ni_prev_q    <= ni_prev_d;
            rd_prev_q    <= rd_prev_d;
            bin_valid_q  <= bin_valid_d;
            bin_idx_q    <= bin_idx_d;
        end
    end

    assign bus.o_ready     = (state_q == S_ACCUM);
    assign bus.o_busy      = (state_q != S_IDLE);
    assign bus.o_done      = (state_q == S_DONE);
    assign bus.o_bin_valid = bin_valid_q;
    assign bus.o_bin_idx   = bin_idx_q;
    assign bus.o_ni_count  = bin_valid_q ? bus.i_ni_rdata : '0;
    assign bus.o_rd_count  = bin_valid_q ? bus.i_rd_rdata : '0;
    assign bus.o_ni_raddr  = ni_raddr;
    assign bus.o_rd_raddr  = rd_raddr;
    assign bus.o_ni_waddr  = ni_waddr;
    assign bus.o_rd_waddr  = rd_waddr;
    assign bus.o_ni_wdata  = ni_wdata;
    assign bus.o_rd_wdata  = rd_wdata;
    assign bus.o_ni_wren   = ni_wren;
    assign bus.o_rd_wren   = rd_wren;

endmodule
`default_nettype wire

// File: tb/tb_ni_rd_hist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ni_rd_hist_ctrl
// Description : Directed bench for ni_rd_hist_ctrl. Two instances run in
//               lockstep from the same stimulus: a 24-bit count build and a
//               4-bit count build that exercises saturation. Each has a pair
//               of behavioural registered-read RAMs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ni_rd_hist_ctrl;
    localparam int WIDTH = 8;
    localparam int DEPTH = 256;
    localparam int CNT_W = 24;
    localparam int SAT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    int   exp_ni [DEPTH];
    int   exp_rd [DEPTH];

    logic [CNT_W-1:0] ni_mem_a [DEPTH];
    logic [CNT_W-1:0] rd_mem_a [DEPTH];
    logic [SAT_W-1:0] ni_mem_b [DEPTH];
    logic [SAT_W-1:0] rd_mem_b [DEPTH];

    ni_rd_hist_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) if_a ();
    ni_rd_hist_ctrl_if #(.WIDTH(WIDTH), .CNT_W(SAT_W)) if_b ();

    ni_rd_hist_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if_a.master)
    );

    ni_rd_hist_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(SAT_W)) u_sat (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if_b.master)
    );

    assign if_b.i_start     = if_a.i_start;
    assign if_b.i_frame_end = if_a.i_frame_end;
    assign if_b.i_valid     = if_a.i_valid;
    assign if_b.i_ni_code   = if_a.i_ni_code;
    assign if_b.i_rd_code   = if_a.i_rd_code;
    assign if_b.i_bin_ready = if_a.i_bin_ready;

    always #5 clk = ~clk;

    // Registered-read RAMs with old-data-on-collision; filled with nonzero
    // junk during reset so an incomplete clear shows up at readout.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ni_mem_a[i] <= CNT_W'(i + 1);
                rd_mem_a[i] <= CNT_W'(i + 3);
                ni_mem_b[i] <= SAT_W'(i % 15 + 1);
                rd_mem_b[i] <= SAT_W'(i % 13 + 1);
            end
        end else begin
            if (if_a.o_ni_wren) ni_mem_a[if_a.o_ni_waddr] <= if_a.o_ni_wdata;
            if (if_a.o_rd_wren) rd_mem_a[if_a.o_rd_waddr] <= if_a.o_rd_wdata;
            if (if_b.o_ni_wren) ni_mem_b[if_b.o_ni_waddr] <= if_b.o_ni_wdata;
            if (if_b.o_rd_wren) rd_mem_b[if_b.o_rd_waddr] <= if_b.o_rd_wdata;
        end
        if_a.i_ni_rdata <= ni_mem_a[if_a.o_ni_raddr];
        if_a.i_rd_rdata <= rd_mem_a[if_a.o_rd_raddr];
        if_b.i_ni_rdata <= ni_mem_b[if_b.o_ni_raddr];
        if_b.i_rd_rdata <= rd_mem_b[if_b.o_rd_raddr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            exp_ni[i] = 0;
            exp_rd[i] = 0;
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_ready"},  32'(if_a.o_ready), 0);
        check_val({tag, "_busy"},   32'(if_a.o_busy), 0);
        check_val({tag, "_done"},   32'(if_a.o_done), 0);
        check_val({tag, "_bvalid"}, 32'(if_a.o_bin_valid), 0);
        check_val({tag, "_wren"},   {30'd0, if_a.o_ni_wren, if_a.o_rd_wren}, 0);
        check_val({tag, "_raddr"},  {16'd0, if_a.o_ni_raddr, if_a.o_rd_raddr}, 0);
        check_val({tag, "_waddr"},  {16'd0, if_a.o_ni_waddr, if_a.o_rd_waddr}, 0);
        check_val({tag, "_ni_wd"},  32'(if_a.o_ni_wdata), 0);
        check_val({tag, "_rd_wd"},  32'(if_a.o_rd_wdata), 0);
        check_val({tag, "_idx"},    32'(if_a.o_bin_idx), 0);
        check_val({tag, "_counts"}, 32'(if_a.o_ni_count | if_a.o_rd_count), 0);
        check_val({tag, "_sat"},    {29'd0, if_b.o_busy, if_b.o_ni_wren, if_b.o_ready}, 0);
    endtask

    // Pulses i_start and watches the 256 clear cycles; returns in cycle 257.
    task automatic start_clear();
        int bad = 0;
        if_a.i_start = 1'b1;
        @(negedge clk);
        if_a.i_start = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if_a.i_frame_end = (k == 10);
            if_a.i_start     = (k == 20);
            if (!(if_a.o_ni_wren && if_a.o_rd_wren && !if_a.o_ready && if_a.o_busy &&
                  if_a.o_ni_waddr == 8'(k) && if_a.o_rd_waddr == 8'(k) &&
                  if_a.o_ni_wdata == '0 && if_a.o_rd_wdata == '0 &&
                  if_b.o_ni_wren && if_b.o_ni_waddr == 8'(k) && if_b.o_rd_wdata == '0))
                bad++;
            @(negedge clk);
        end
        if_a.i_frame_end = 1'b0;
        if_a.i_start     = 1'b0;
        check_val("clear_bad_cycles", bad, 0);
        check_val("ready_cycle_257", 32'(if_a.o_ready), 1);
        check_val("accum_idle_wren", 32'(if_a.o_ni_wren), 0);
    endtask

    // Drives one cycle of pixel input; returns at the next falling edge.
    task automatic send_pixel(input logic v, input logic [7:0] ni, input logic [7:0] rd, input logic fe);
        if_a.i_valid     = v;
        if_a.i_ni_code   = ni;
        if_a.i_rd_code   = rd;
        if_a.i_frame_end = fe;
        if (v) begin
            exp_ni[ni]++;
            exp_rd[rd]++;
        end
        @(negedge clk);
        if_a.i_valid     = 1'b0;
        if_a.i_frame_end = 1'b0;
    endtask

    // Collects all bins with i_bin_ready low bp percent of the time.
    task automatic readout(input int bp, input string tag);
        int b = 0;
        int guard = 0;
        int unstable = 0;
        int early_done = 0;
        logic rdy;
        logic held = 1'b0;
        logic [WIDTH-1:0] h_idx = '0;
        logic [CNT_W-1:0] h_ni = '0;
        logic [CNT_W-1:0] h_rd = '0;
        while (b < DEPTH && guard < 8 * DEPTH) begin
            rdy = ($urandom_range(99) >= 32'(bp));
            if_a.i_bin_ready = rdy;
            if (if_a.o_done) early_done++;
            if (if_a.o_bin_valid) begin
                if (!if_b.o_bin_valid) unstable++;
                if (held && (h_idx != if_a.o_bin_idx || h_ni != if_a.o_ni_count || h_rd != if_a.o_rd_count))
                    unstable++;
                if (rdy) begin
                    check_val({tag, "_idx"},    32'(if_a.o_bin_idx), b);
                    check_val({tag, "_ni"},     32'(if_a.o_ni_count), exp_ni[b]);
                    check_val({tag, "_rd"},     32'(if_a.o_rd_count), exp_rd[b]);
                    check_val({tag, "_sat_ni"}, 32'(if_b.o_ni_count), sat15(exp_ni[b]));
                    check_val({tag, "_sat_rd"}, 32'(if_b.o_rd_count), sat15(exp_rd[b]));
                    held = 1'b0;
                    b++;
                end else begin
                    held  = 1'b1;
                    h_idx = if_a.o_bin_idx;
                    h_ni  = if_a.o_ni_count;
                    h_rd  = if_a.o_rd_count;
                end
            end
            @(negedge clk);
            guard++;
        end
        if_a.i_bin_ready = 1'b0;
        check_val({tag, "_bins"}, b, DEPTH);
        check_val({tag, "_unstable"}, unstable, 0);
        check_val({tag, "_early_done"}, early_done, 0);
        if (bp == 0) check_val({tag, "_cycles"}, guard, 2 * DEPTH - 1);
        check_val({tag, "_done"}, 32'(if_a.o_done), 1);
        check_val({tag, "_busy_at_done"}, 32'(if_a.o_busy), 1);
        @(negedge clk);
        check_val({tag, "_done_once"}, 32'(if_a.o_done), 0);
        check_val({tag, "_busy_after"}, 32'(if_a.o_busy), 0);
    endtask

    function automatic logic [7:0] pick(input logic [7:0] last, input logic [7:0] prev2);
        case ($urandom_range(3))
            0:       return last;
            1:       return prev2;
            default: return 8'($urandom_range(255));
        endcase
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        logic v;
        logic [7:0] nc, rc, n1, n2, r1, r2;
        if_a.i_start     = 1'b0;
        if_a.i_frame_end = 1'b0;
        if_a.i_valid     = 1'b0;
        if_a.i_ni_code   = '0;
        if_a.i_rd_code   = '0;
        if_a.i_bin_ready = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_busy", 32'(if_a.o_busy), 0);

        // Same-address hazard; pixels offered during CLEAR must be ignored.
        if_a.i_valid   = 1'b1;
        if_a.i_ni_code = 8'h99;
        if_a.i_rd_code = 8'h99;
        start_clear();
        for (int i = 0; i < 5; i++) begin
            send_pixel(1'b1, 8'h12, 8'h34, i == 4);
            check_val("haz_ni_wdata", 32'(if_a.o_ni_wdata), i + 1);
            check_val("haz_rd_wdata", 32'(if_a.o_rd_wdata), i + 1);
            check_val("haz_waddr", {16'd0, if_a.o_ni_waddr, if_a.o_rd_waddr}, 32'h1234);
        end
        check_val("drain_ready", 32'(if_a.o_ready), 0);
        check_val("drain_wren", 32'(if_a.o_ni_wren), 1);
        check_val("drain_bvalid", 32'(if_a.o_bin_valid), 0);
        @(negedge clk);
        check_val("rdreq_wren", 32'(if_a.o_ni_wren), 0);
        check_val("rdreq_bvalid", 32'(if_a.o_bin_valid), 0);
        check_val("rdreq_raddr", {16'd0, if_a.o_ni_raddr, if_a.o_rd_raddr}, 0);
        @(negedge clk);
        check_val("rdout_bvalid", 32'(if_a.o_bin_valid), 1);
        readout(0, "haz");

        // Random codes with gaps, A,A,B and A,B,A patterns, stray i_start.
        clear_model();
        start_clear();
        acc = 0;
        n1 = 8'h00; n2 = 8'h00; r1 = 8'h00; r2 = 8'h00;
        while (acc < 10000) begin
            v  = ($urandom_range(3) != 0);
            nc = pick(n1, n2);
            rc = pick(r1, r2);
            if_a.i_start = (acc == 5000);
            send_pixel(v, nc, rc, v && acc == 9999);
            if_a.i_start = 1'b0;
            if (v) begin
                n2 = n1; n1 = nc;
                r2 = r1; r1 = rc;
                acc++;
            end
        end
        readout(30, "rnd");

        // Saturation: 24-bit build counts 20, 4-bit build stops at 15.
        clear_model();
        start_clear();
        for (int i = 0; i < 20; i++) send_pixel(1'b1, 8'h07, 8'h70, i == 19);
        readout(30, "sat");

        // Mid-frame reset with a pixel still in flight.
        clear_model();
        start_clear();
        send_pixel(1'b1, 8'h21, 8'h43, 1'b0);
        send_pixel(1'b1, 8'h21, 8'h44, 1'b0);
        if_a.i_valid   = 1'b1;
        if_a.i_ni_code = 8'h55;
        if_a.i_rd_code = 8'h66;
        #1 rst = 1'b1;
        #1 check_zero("midrst");
        @(negedge clk);
        check_zero("midrst_clk");
        rst = 1'b0;
        if_a.i_valid = 1'b0;
        @(negedge clk);
        check_val("post_rst_busy", 32'(if_a.o_busy), 0);
        clear_model();
        start_clear();
        for (int i = 0; i < 3; i++) send_pixel(1'b1, 8'hFF, 8'hFF, i == 2);
        readout(30, "rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
